// File: rtl/key_conditioner.sv
// Board input front-end: synchronizes slide switches, debounces active-low
// push-buttons and generates press, release and auto-repeat strobes.
module key_conditioner #(
   parameter int NUM_KEYS        = 2,
   parameter int SW_W            = 10,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic                clk100_i,
   input  logic                rst_i,
   input  logic [NUM_KEYS-1:0] key_i,
   input  logic [SW_W-1:0]     sw_i,
   output logic [SW_W-1:0]     sw_o,
   output logic                sw_chg_o,
   output logic [NUM_KEYS-1:0] key_lvl_o,
   output logic [NUM_KEYS-1:0] key_press_o,
   output logic [NUM_KEYS-1:0] key_rel_o,
   output logic [NUM_KEYS-1:0] key_rep_o
);

   localparam int DC_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DC_W-1:0] DC_LAST = DC_W'(DEBOUNCE_CYCLES - 1);
   localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RC_W = $clog2(RC_MAX + 1);

   typedef enum logic {PH_DELAY, PH_PERIOD} phase_t;

   logic [SW_W-1:0] sw_s1_reg;
   logic [SW_W-1:0] sw_reg;
   logic [SW_W-1:0] sw_d_reg;
   logic            sw_chg_reg;

   // sw_d_reg trails sw_reg by one cycle so the change strobe is registered.
   always_ff @(posedge clk100_i) begin
      if (rst_i) begin
         sw_s1_reg  <= '0;
         sw_reg     <= '0;
         sw_d_reg   <= '0;
         sw_chg_reg <= 1'b0;
      end else begin
         sw_s1_reg  <= sw_i;
         sw_reg     <= sw_s1_reg;
         sw_d_reg   <= sw_reg;
         sw_chg_reg <= (sw_reg != sw_d_reg);
      end
   end

   assign sw_o     = sw_reg;
   assign sw_chg_o = sw_chg_reg;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         logic            key_s1_reg;
         logic            key_s2_reg;
         logic            ps;
         logic [DC_W-1:0] dc_reg;
         logic            lvl_reg;
         logic            press_reg;
         logic            rel_reg;
         logic            accept;
         logic            press_now;
         logic            rel_now;

         // Synchronizer keeps the raw active-low polarity; released = 1.
         assign ps        = ~key_s2_reg;
         assign accept    = (ps != lvl_reg) && (dc_reg == DC_LAST);
         assign press_now = accept && ps;
         assign rel_now   = accept && !ps;

         always_ff @(posedge clk100_i) begin
            if (rst_i) begin
               key_s1_reg <= 1'b1;
               key_s2_reg <= 1'b1;
               dc_reg     <= '0;
               lvl_reg    <= 1'b0;
               press_reg  <= 1'b0;
               rel_reg    <= 1'b0;
            end else begin
               key_s1_reg <= key_i[gi];
               key_s2_reg <= key_s1_reg;
               press_reg  <= press_now;
               rel_reg    <= rel_now;
               if (ps == lvl_reg) begin
                  dc_reg <= '0;
               end else if (dc_reg == DC_LAST) begin
                  lvl_reg <= ps;
                  dc_reg  <= '0;
               end else begin
                  dc_reg <= dc_reg + 1'b1;
               end
            end
         end

         assign key_lvl_o[gi]   = lvl_reg;
         assign key_press_o[gi] = press_reg;
         assign key_rel_o[gi]   = rel_reg;

         if (REPEAT_DELAY > 0) begin : g_rep
            localparam logic [RC_W-1:0] RD_LAST = RC_W'(REPEAT_DELAY - 1);
            localparam logic [RC_W-1:0] RP_LAST = RC_W'(REPEAT_PERIOD - 1);

            phase_t          phase_reg, phase_next;
            logic [RC_W-1:0] rc_reg, rc_next;
            logic            rep_reg, rep_next;

            always_ff @(posedge clk100_i) begin
               if (rst_i) begin
                  phase_reg <= PH_DELAY;
                  rc_reg    <= '0;
                  rep_reg   <= 1'b0;
               end else begin
                  phase_reg <= phase_next;
                  rc_reg    <= rc_next;
                  rep_reg   <= rep_next;
               end
            end

            // Press and release-acceptance edges restart the schedule, which
            // keeps the repeat strobe off both of them.
            always_comb begin
               phase_next = phase_reg;
               rc_next    = rc_reg;
               rep_next   = 1'b0;
               if (press_now || rel_now || !lvl_reg) begin
                  phase_next = PH_DELAY;
                  rc_next    = '0;
               end else if (phase_reg == PH_DELAY && rc_reg == RD_LAST) begin
                  phase_next = PH_PERIOD;
                  rc_next    = '0;
                  rep_next   = 1'b1;
               end else if (phase_reg == PH_PERIOD && rc_reg == RP_LAST) begin
                  rc_next    = '0;
                  rep_next   = 1'b1;
               end else begin
                  rc_next    = rc_reg + 1'b1;
               end
            end

            assign key_rep_o[gi] = rep_reg;
         end else begin : g_no_rep
            assign key_rep_o[gi] = 1'b0;
         end
      end
   endgenerate

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3, plus a second instance with auto-repeat disabled.
module tb_key_conditioner;

   logic       clk;
   logic       rst;
   logic [1:0] key;
   logic [9:0] sw;

   logic [9:0] a_sw_o, z_sw_o;
   logic       a_sw_chg, z_sw_chg;
   logic [1:0] a_lvl, a_press, a_rel, a_rep;
   logic [1:0] z_lvl, z_press, z_rel, z_rep;

   int tests = 0;
   int fails = 0;

   key_conditioner #(
      .NUM_KEYS(2), .SW_W(10), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
   ) dut (
      .clk100_i(clk), .rst_i(rst), .key_i(key), .sw_i(sw),
      .sw_o(a_sw_o), .sw_chg_o(a_sw_chg), .key_lvl_o(a_lvl),
      .key_press_o(a_press), .key_rel_o(a_rel), .key_rep_o(a_rep)
   );

   key_conditioner #(
      .NUM_KEYS(2), .SW_W(10), .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(0), .REPEAT_PERIOD(3)
   ) dut_norep (
      .clk100_i(clk), .rst_i(rst), .key_i(key), .sw_i(sw),
      .sw_o(z_sw_o), .sw_chg_o(z_sw_chg), .key_lvl_o(z_lvl),
      .key_press_o(z_press), .key_rel_o(z_rel), .key_rep_o(z_rep)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int cnt_a, cnt_b, cnt_c;
      logic [9:0] prev, val;

      // 1. Reset with keys pressed and switches all high
      rst = 1'b1; key = 2'b00; sw = 10'h3FF;
      tick(3);
      check("rst_sw_o", 32'(a_sw_o), 32'h0);
      check("rst_sw_chg", 32'(a_sw_chg), 32'h0);
      check("rst_lvl", 32'(a_lvl), 32'h0);
      check("rst_press", 32'(a_press), 32'h0);
      check("rst_rel", 32'(a_rel), 32'h0);
      check("rst_rep", 32'(a_rep), 32'h0);
      rst = 1'b0;
      tick(1); check("rel_sw_e1", 32'(a_sw_o), 32'h0);
      tick(1); check("rel_sw_e2", 32'(a_sw_o), 32'h3FF);
               check("rel_chg_e2", 32'(a_sw_chg), 32'h0);
      tick(1); check("rel_chg_e3", 32'(a_sw_chg), 32'h1);
      tick(1); check("rel_chg_e4", 32'(a_sw_chg), 32'h0);
      tick(1); check("rel_lvl_e5", 32'(a_lvl), 32'h0);
               check("rel_press_e5", 32'(a_press), 32'h0);
      tick(1); check("rel_lvl_e6", 32'(a_lvl), 32'h3);
               check("rel_press_e6", 32'(a_press), 32'h3);
               check("rel_press_e6_norep", 32'(z_press), 32'h3);
      tick(1); check("rel_press_e7", 32'(a_press), 32'h0);
      key = 2'b11;
      tick(6); check("rst_keys_rel", 32'(a_rel), 32'h3);
               check("rst_keys_lvl", 32'(a_lvl), 32'h0);
      tick(1); check("rst_keys_rel_end", 32'(a_rel), 32'h0);
      cnt_a = 0;
      for (int t = 0; t < 5; t++) begin
         tick(1);
         cnt_a += int'(a_rep[0]) + int'(a_rep[1]);
      end
      check("rst_keys_no_rep", 32'(cnt_a), 32'h0);

      // 2. Clean press on key 0, hold through three repeats
      key = 2'b10;
      for (int t = 1; t <= 22; t++) begin
         tick(1);
         check($sformatf("press_t%0d", t), 32'(a_press[0]), 32'(t == 6));
         check($sformatf("lvl_t%0d", t), 32'(a_lvl[0]), 32'(t >= 6));
         check($sformatf("rep_t%0d", t), 32'(a_rep[0]), 32'(t == 16 || t == 19 || t == 22));
      end
      key = 2'b11;
      for (int t = 1; t <= 8; t++) begin
         tick(1);
         check($sformatf("release_rep_t%0d", t), 32'(a_rep[0]), 32'(t == 3));
         check($sformatf("release_rel_t%0d", t), 32'(a_rel[0]), 32'(t == 6));
         check($sformatf("release_lvl_t%0d", t), 32'(a_lvl[0]), 32'(t < 6));
      end
      cnt_a = 0;
      for (int t = 0; t < 10; t++) begin
         tick(1);
         cnt_a += int'(a_rep[0]);
      end
      check("post_release_no_rep", 32'(cnt_a), 32'h0);

      // 3. Bounce on key 1: 3 low, 2 high, 3 low, then high
      cnt_a = 0;
      key = 2'b01; tick(3);
      key = 2'b11; tick(2);
      key = 2'b01;
      for (int t = 0; t < 3; t++) begin
         tick(1);
         cnt_a += int'(a_lvl[1]) + int'(a_press[1]) + int'(a_rel[1]) + int'(a_rep[1]);
      end
      key = 2'b11;
      for (int t = 0; t < 10; t++) begin
         tick(1);
         cnt_a += int'(a_lvl[1]) + int'(a_press[1]) + int'(a_rel[1]) + int'(a_rep[1]);
      end
      check("bounce_no_activity", 32'(cnt_a), 32'h0);
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      key = 2'b01;
      for (int t = 1; t <= 18; t++) begin
         tick(1);
         if (t == 4) key = 2'b11;
         cnt_a += int'(a_press[1]);
         cnt_b += int'(a_rel[1]);
         cnt_c += int'(a_rep[1]) + int'(a_press[0]);
      end
      check("long_low_press_cnt", 32'(cnt_a), 32'h1);
      check("long_low_rel_cnt", 32'(cnt_b), 32'h1);
      check("long_low_other", 32'(cnt_c), 32'h0);

      // 4. Switch sweep, one window forced to repeat the previous value
      prev = 10'h3FF;
      for (int i = 0; i < 6; i++) begin
         val = (i == 2) ? prev : 10'($urandom_range(0, 1023));
         sw = val;
         cnt_a = 0;
         for (int t = 1; t <= 22; t++) begin
            tick(1);
            if (t == 1) check($sformatf("sw_hold_%0d", i), 32'(a_sw_o), 32'(prev));
            if (t == 2) check($sformatf("sw_new_%0d", i), 32'(a_sw_o), 32'(val));
            cnt_a += int'(a_sw_chg);
         end
         check($sformatf("sw_chg_cnt_%0d", i), 32'(cnt_a), 32'(val != prev));
         prev = val;
      end

      // 5. Reset during the delay phase (rc = 5) with key 0 held
      key = 2'b10;
      tick(11);
      check("mid_lvl_before_rst", 32'(a_lvl[0]), 32'h1);
      rst = 1'b1;
      tick(1);
      check("mid_rst_sw_o", 32'(a_sw_o), 32'h0);
      check("mid_rst_sw_chg", 32'(a_sw_chg), 32'h0);
      check("mid_rst_lvl", 32'(a_lvl), 32'h0);
      check("mid_rst_press", 32'(a_press), 32'h0);
      check("mid_rst_rel", 32'(a_rel), 32'h0);
      check("mid_rst_rep", 32'(a_rep), 32'h0);
      rst = 1'b0;
      for (int t = 1; t <= 16; t++) begin
         tick(1);
         if (t == 2) check("mid_sw_back", 32'(a_sw_o), 32'(prev));
         check($sformatf("mid_press_t%0d", t), 32'(a_press[0]), 32'(t == 6));
         check($sformatf("mid_rep_t%0d", t), 32'(a_rep[0]), 32'(t == 16));
      end
      key = 2'b11;
      tick(20);

      // 6. Auto-repeat disabled instance, key held 100 cycles
      key = 2'b10;
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      for (int t = 1; t <= 100; t++) begin
         tick(1);
         cnt_a += int'(z_press[0]);
         cnt_b += int'(z_rep[0]) + int'(z_rep[1]);
         cnt_c += int'(a_rep[0]);
      end
      check("norep_press_cnt", 32'(cnt_a), 32'h1);
      check("norep_rep_cnt", 32'(cnt_b), 32'h0);
      check("norep_lvl", 32'(z_lvl[0]), 32'h1);
      check("rep_cnt_100", 32'(cnt_c), 32'd29);
      key = 2'b11;
      tick(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Input front-end for the practicum boards. It takes the raw, active-low push-buttons and the slide switches and turns them into clean, clock-aligned signals for the counter/display blocks:
- synchronized switch levels;
- debounced key levels;
- one-cycle press, release and auto-repeat strobes.

It sits between the board pins and every lab core that consumes `key_i`/`sw_i`.

## Interface
- `NUM_KEYS`, 2: number of push-buttons.
- `SW_W`, 10: slide-switch width.
- `DEBOUNCE_CYCLES`, 500000: cycles the synchronized key must differ from its debounced level before the level is accepted. Must be ≥1.
- `REPEAT_DELAY`, 25000000: cycles from a press strobe to the first repeat strobe. 0 disables auto-repeat.
- `REPEAT_PERIOD`, 5000000: cycles between consecutive repeat strobes. Must be ≥1.

Ports:
- `clk100_i`  in  1  system clock; all logic on its rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `key_i`  in  NUM_KEYS  raw buttons, active-low (0 = pressed), asynchronous.
- `sw_i`  in  SW_W  raw switches, asynchronous.
- `sw_o`  out  SW_W  switches after a two-flop synchronizer.
- `sw_chg_o`  out  1  one-cycle strobe when `sw_o` changes value.
- `key_lvl_o`  out  NUM_KEYS  debounced level, active-high (1 = pressed).
- `key_press_o`  out  NUM_KEYS  one-cycle strobe on a debounced 0→1 of `key_lvl_o`.
- `key_rel_o`  out  NUM_KEYS  one-cycle strobe on a debounced 1→0 of `key_lvl_o`.
- `key_rep_o`  out  NUM_KEYS  one-cycle auto-repeat strobe while held.

## Operation
- Reset values; `rst_i` sampled high forces all of these on the next edge, overriding any operation in progress:
  - key synchronizer flops = 1 (released);
  - switch synchronizer flops = 0;
  - `sw_o` = 0;
  - `key_lvl_o` = 0;
  - all strobes = 0;
  - all counters = 0.
- Switch path:
  - `sw_i` → s1 → `sw_o`, two flops.
  - `sw_chg_o` = 1 for one cycle, registered, in the cycle after any bit of `sw_o` changes.
- Key path, per key `k`, independent:
  - `pk` = ~`key_i[k]` passes through two synchronizer flops to give `ps`.
  - Debounce counter `dc`, width $clog2(DEBOUNCE_CYCLES+1):
    - if `ps` == `key_lvl_o[k]`: `dc` ← 0;
    - else if `dc` == DEBOUNCE_CYCLES-1: `key_lvl_o[k]` ← `ps`, `dc` ← 0, and the press or release strobe is asserted on the same edge;
    - else `dc` ← `dc`+1.
  - Any bounce that returns `ps` to the current level before acceptance restarts the count. The strobes never fire for such glitches.
- Auto-repeat, per key, active only when REPEAT_DELAY > 0. Repeat counter `rc`, width sized for max(REPEAT_DELAY, REPEAT_PERIOD):
  - cleared on the press-strobe edge; phase = DELAY;
  - while `key_lvl_o[k]`=1, increments each cycle;
  - DELAY phase: when `rc` reaches REPEAT_DELAY-1, `key_rep_o[k]` ← 1, `rc` ← 0, phase ← PERIOD;
  - PERIOD phase: when `rc` reaches REPEAT_PERIOD-1, `key_rep_o[k]` ← 1, `rc` ← 0;
  - on release (`key_lvl_o`=0), `rc` and phase are held at 0/DELAY and no repeat strobe fires.
- Mutual exclusion per key:
  - press and release strobes never coincide;
  - a repeat strobe never coincides with a press strobe (`rc` is cleared then);
  - a repeat strobe never fires on the release-acceptance edge.
- Simultaneous events on different keys are fully independent; strobes may coincide across keys.

## Timing
- Switch latency: a `sw_i` change that is stable before edge 0 appears on `sw_o` after edge 2, and `sw_chg_o` pulses after edge 3.
- Key latency: a `key_i` change that is stable before edge 0 gives:
  - `ps` updated after edge 2;
  - `key_lvl_o` and the press/release strobe updated after edge 2+DEBOUNCE_CYCLES.
- Repeat timing after a press strobe at edge P:
  - first repeat at edge P+REPEAT_DELAY;
  - then every REPEAT_PERIOD edges.
- Every strobe is exactly one cycle wide. All outputs come straight from flops, with no combinational paths from inputs.
- If `key_i` is held pressed through reset release, the press strobe occurs DEBOUNCE_CYCLES+2 edges after the first non-reset edge.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.

1. **Reset.** Hold `rst_i`=1 with `key_i`=2'b00 and `sw_i`=10'h3FF → all outputs 0. Release reset → `key_lvl_o`=2'b11 and `key_press_o`=2'b11 at edge 6 after release. `sw_o`=10'h3FF at edge 2 and `sw_chg_o`=1 at edge 3.
2. **Clean press.** `key_i[0]`: 1→0 before edge 0 → `key_press_o[0]` high for exactly cycle 6. Hold → `key_rep_o[0]` at edges 16, 19, 22. Release → `key_rel_o[0]` 6 edges after the release, and no further repeats.
3. **Bounce.** `key_i[1]` toggles with a 3-cycle low, 2-cycle high, 3-cycle low pattern, then stays high → `key_lvl_o[1]` stays 0 and no strobes. Then a 4+ cycle low → exactly one press strobe.
4. **Switch sweep.** `sw_i` ← $random every 22 cycles → `sw_o` equals `sw_i` delayed 2 cycles. One `sw_chg_o` per change, none when the random value repeats.
5. **Reset mid-operation.** `rst_i` asserted during the DELAY phase, e.g. at `rc`=5 → the next edge clears all outputs. No repeat strobe at the old schedule. A held key re-presses 6 edges after reset release.
6. **Repeat disabled.** REPEAT_DELAY=0, key held for 100 cycles → single press strobe, `key_rep_o` constantly 0.
